// File: rtl/lbp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lbp_engine
// Description : Local-binary-pattern engine; walks interior pixels of a host
//               frame via a read port and writes 8-bit LBP codes back.
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DW     = 8,
    parameter int AW     = 14,
    parameter int MODE   = 0,
    parameter int THRESH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int            C_DW1      = DW + 1;
    localparam logic [AW-1:0] C_W        = AW'(IMG_W);
    localparam logic [AW-1:0] C_LAST_X   = AW'(IMG_W - 2);
    localparam logic [AW-1:0] C_LAST_Y   = AW'(IMG_H - 2);
    localparam logic [AW-1:0] C_ONE      = AW'(1);
    localparam logic [DW:0]   C_THRESH   = C_DW1'(THRESH);
    localparam logic [DW-1:0] C_PIX_MAX  = {DW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] x_q, x_d;
    logic [AW-1:0] y_q, y_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic [DW-1:0] win_q [0:8];
    logic [DW-1:0] win_d [0:8];
    logic [7:0]    lbp_data_q, lbp_data_d;
    logic [AW-1:0] lbp_addr_q, lbp_addr_d;

    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic [AW-1:0] rd_x;
    logic [AW-1:0] rd_y;
    logic [AW-1:0] rd_addr;
    logic          rd_active;
    logic [DW-1:0] centre;
    logic [DW:0]   thr_sum;
    logic [DW-1:0] thr_sat;
    logic [DW-1:0] thr;
    logic [7:0]    code;
    logic [3:0]    shift_slot;

    // Read address: LOAD walks the full 3x3 window, SHIFT only the right column.
    always_comb begin
        rd_row = '0;
        rd_col = '0;
        if (state_q == S_LOAD) begin
            rd_row = AW'(rd_idx_q / 4'd3);
            rd_col = AW'(rd_idx_q % 4'd3);
        end else begin
            rd_row = AW'(rd_idx_q);
            rd_col = AW'(2);
        end
        rd_x    = x_q + rd_col - C_ONE;
        rd_y    = y_q + rd_row - C_ONE;
        rd_addr = rd_y * C_W + rd_x;
    end

    assign rd_active = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign gray_req  = rd_active && gray_ready;
    assign gray_addr = gray_req ? rd_addr : '0;

    // Threshold sum carries one extra bit so it saturates instead of wrapping.
    always_comb begin
        centre  = win_q[4];
        thr_sum = {1'b0, centre} + C_THRESH;
        thr_sat = thr_sum[DW] ? C_PIX_MAX : thr_sum[DW-1:0];
        thr     = (MODE == 0) ? centre : thr_sat;
        code[0] = (win_q[0] >= thr);
        code[1] = (win_q[1] >= thr);
        code[2] = (win_q[2] >= thr);
        code[3] = (win_q[3] >= thr);
        code[4] = (win_q[5] >= thr);
        code[5] = (win_q[6] >= thr);
        code[6] = (win_q[7] >= thr);
        code[7] = (win_q[8] >= thr);
    end

    assign shift_slot = 4'd2 + rd_idx_q * 4'd3;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        rd_idx_d   = rd_idx_q;
        win_d      = win_q;
        lbp_data_d = lbp_data_q;
        lbp_addr_d = lbp_addr_q;
        case (state_q)
            S_IDLE: begin
                if (gray_ready) begin
                    state_d  = S_LOAD;
                    rd_idx_d = '0;
                end
            end
            S_LOAD: begin
                if (gray_ready) begin
                    win_d[rd_idx_q] = gray_data;
                    if (rd_idx_q == 4'd8) begin
                        rd_idx_d = '0;
                        state_d  = S_CALC;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                    end
                end
            end
            S_SHIFT: begin
                if (gray_ready) begin
                    win_d[shift_slot] = gray_data;
                    if (rd_idx_q == 4'd2) begin
                        rd_idx_d = '0;
                        state_d  = S_CALC;
                    end else begin
                        rd_idx_d = rd_idx_q + 4'd1;
                    end
                end
            end
            S_CALC: begin
                lbp_data_d = code;
                lbp_addr_d = y_q * C_W + x_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                if (x_q < C_LAST_X) begin
                    x_d     = x_q + C_ONE;
                    state_d = S_SHIFT;
                    // Slide the two reusable columns left before the new column arrives.
                    for (int r = 0; r < 3; r++) begin
                        win_d[3*r]   = win_q[3*r+1];
                        win_d[3*r+1] = win_q[3*r+2];
                    end
                end else if (y_q < C_LAST_Y) begin
                    x_d     = C_ONE;
                    y_d     = y_q + C_ONE;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            x_q        <= C_ONE;
            y_q        <= C_ONE;
            rd_idx_q   <= '0;
            win_q      <= '{default: '0};
            lbp_data_q <= '0;
            lbp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_idx_q   <= rd_idx_d;
            win_q      <= win_d;
            lbp_data_q <= lbp_data_d;
            lbp_addr_q <= lbp_addr_d;
        end
    end

    assign lbp_valid = (state_q == S_WRITE);
    assign finish    = (state_q == S_DONE);
    assign lbp_data  = lbp_data_q;
    assign lbp_addr  = lbp_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lbp_engine
// Description : Scoreboard bench for lbp_engine on small 8x6 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, ready_a, req_a, valid_a, fin_a;
    logic [5:0] gaddr_a, laddr_a;
    logic [7:0] gdata_a, ldata_a;
    logic       rst_n_b, ready_b, req_b, valid_b, fin_b;
    logic [5:0] gaddr_b, laddr_b;
    logic [9:0] gdata_b;
    logic [7:0] ldata_b;

    logic [7:0] mem_a [0:63];
    logic [9:0] mem_b [0:63];
    logic [7:0] code_tbl [0:63];

    assign gdata_a = mem_a[gaddr_a];
    assign gdata_b = mem_b[gaddr_b];

    lbp_engine #(.IMG_W(8), .IMG_H(6), .DW(8), .AW(6), .MODE(0), .THRESH(4)) u_a (
        .clk(clk), .reset(rst_n_a), .gray_ready(ready_a), .gray_req(req_a),
        .gray_addr(gaddr_a), .gray_data(gdata_a), .lbp_addr(laddr_a),
        .lbp_valid(valid_a), .lbp_data(ldata_a), .finish(fin_a)
    );

    lbp_engine #(.IMG_W(8), .IMG_H(6), .DW(10), .AW(6), .MODE(1), .THRESH(4)) u_b (
        .clk(clk), .reset(rst_n_b), .gray_ready(ready_b), .gray_req(req_b),
        .gray_addr(gaddr_b), .gray_data(gdata_b), .lbp_addr(laddr_b),
        .lbp_valid(valid_b), .lbp_data(ldata_b), .finish(fin_b)
    );

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e_a, e_b;
    int   n_vec = 0;
    int   n_err = 0;
    logic vd_a, vd_b;

    always @(posedge clk) begin
        vd_a <= valid_a;
        vd_b <= valid_b;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Scoreboard monitors: pop one expectation per write strobe.
    always @(negedge clk) begin
        if (valid_a) begin
            if (exp_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_extra_strobe: got strobe at addr %0d, expected none", laddr_a);
            end else begin
                e_a = exp_a.pop_front();
                check("a_lbp_addr", 32'(laddr_a), 32'(e_a.addr));
                check("a_lbp_data", 32'(ldata_a), 32'(e_a.data));
            end
        end
        if (req_a && valid_a) begin
            n_vec++;
            n_err++;
            $display("FAIL a_req_with_valid: got req=1 valid=1, expected not both");
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_extra_strobe: got strobe at addr %0d, expected none", laddr_b);
            end else begin
                e_b = exp_b.pop_front();
                check("b_lbp_addr", 32'(laddr_b), 32'(e_b.addr));
                check("b_lbp_data", 32'(ldata_b), 32'(e_b.data));
            end
        end
        if (req_b && valid_b) begin
            n_vec++;
            n_err++;
            $display("FAIL b_req_with_valid: got req=1 valid=1, expected not both");
        end
    end

    task automatic set_codes(input logic [7:0] bg);
        foreach (code_tbl[i]) code_tbl[i] = bg;
    endtask

    task automatic push_exp(input bit sel);
        exp_t t;
        for (int y = 1; y <= 4; y++) begin
            for (int x = 1; x <= 6; x++) begin
                t.addr = 6'(y * 8 + x);
                t.data = code_tbl[y * 8 + x];
                if (sel) exp_b.push_back(t);
                else     exp_a.push_back(t);
            end
        end
    endtask

    task automatic do_reset(input bit sel);
        @(negedge clk);
        if (sel) begin rst_n_b = 1'b0; ready_b = 1'b0; end
        else     begin rst_n_a = 1'b0; ready_a = 1'b0; end
        repeat (2) @(negedge clk);
        if (sel) rst_n_b = 1'b1;
        else     rst_n_a = 1'b1;
    endtask

    // Call right after raising ready at a negedge while the engine idles.
    task automatic run_frame(input bit sel, input int want_cyc);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        @(posedge clk);
        while (!done && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            #1;
            done = sel ? fin_b : fin_a;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_frame_timeout: got no finish in %0d cycles, expected %0d", sel ? "b" : "a", cyc, want_cyc);
        end else begin
            check(sel ? "b_frame_cycles" : "a_frame_cycles", 32'(cyc), 32'(want_cyc));
            check(sel ? "b_finish_after_last" : "a_finish_after_last", 32'(sel ? vd_b : vd_a), 32'd1);
        end
        @(negedge clk);
        check(sel ? "b_strobes_left" : "a_strobes_left", 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
    endtask

    task automatic wait_strobes(input bit sel, input int k);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < k && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (sel ? valid_b : valid_a) seen++;
        end
        if (seen < k) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_strobes: got %0d strobes, expected %0d", seen, k);
        end
    endtask

    task automatic stall_a();
        wait_strobes(1'b0, 1);
        @(negedge clk);
        ready_a = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("a_req_during_stall", 32'(req_a), 32'd0);
        end
        @(negedge clk);
        ready_a = 1'b1;
    endtask

    task automatic load_pattern_a();
        foreach (mem_a[i]) mem_a[i] = 8'd0;
        mem_a[0]  = 8'd99;  mem_a[1]  = 8'd99; mem_a[2]  = 8'd100;
        mem_a[8]  = 8'd99;  mem_a[9]  = 8'd100; mem_a[10] = 8'd99;
        mem_a[16] = 8'd99;  mem_a[17] = 8'd99; mem_a[18] = 8'd99;
        set_codes(8'hFF);
        code_tbl[9]  = 8'h04;
        code_tbl[10] = 8'h6B;
        code_tbl[17] = 8'h1F;
        code_tbl[18] = 8'h0B;
    endtask

    initial begin
        rst_n_a = 1'b0; ready_a = 1'b0;
        rst_n_b = 1'b0; ready_b = 1'b0;
        foreach (mem_a[i]) mem_a[i] = 8'h50;
        foreach (mem_b[i]) mem_b[i] = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_outputs", 32'({req_a, gaddr_a, valid_a, ldata_a, laddr_a, fin_a}), 32'd0);
        check("b_reset_outputs", 32'({req_b, gaddr_b, valid_b, ldata_b, laddr_b, fin_b}), 32'd0);

        // Flat frame: every neighbour equals the centre.
        set_codes(8'hFF);
        push_exp(1'b0);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        ready_a = 1'b1;
        run_frame(1'b0, 144);

        // Directed neighbourhood around (1,1).
        load_pattern_a();
        do_reset(1'b0);
        push_exp(1'b0);
        ready_a = 1'b1;
        run_frame(1'b0, 144);

        // Same frame with a 5-cycle input stall inside the first SHIFT.
        do_reset(1'b0);
        push_exp(1'b0);
        ready_a = 1'b1;
        fork
            run_frame(1'b0, 149);
            stall_a();
        join

        // Reset on the edge right after the 10th strobe, then a full restart.
        do_reset(1'b0);
        push_exp(1'b0);
        ready_a = 1'b1;
        wait_strobes(1'b0, 10);
        rst_n_a = 1'b0;
        @(posedge clk);
        #1;
        check("a_midframe_reset_outputs", 32'({req_a, gaddr_a, valid_a, ldata_a, laddr_a, fin_a}), 32'd0);
        exp_a.delete();
        push_exp(1'b0);
        @(negedge clk);
        rst_n_a = 1'b1;
        run_frame(1'b0, 144);

        // Threshold mode, centre 100 with 104 edges and 103 corners.
        mem_b[0]  = 10'd103; mem_b[1]  = 10'd104; mem_b[2]  = 10'd103;
        mem_b[8]  = 10'd104; mem_b[9]  = 10'd100; mem_b[10] = 10'd104;
        mem_b[16] = 10'd103; mem_b[17] = 10'd104; mem_b[18] = 10'd103;
        set_codes(8'h00);
        code_tbl[9]  = 8'h5A;
        code_tbl[11] = 8'h29; code_tbl[19] = 8'h09;
        code_tbl[25] = 8'h07; code_tbl[26] = 8'h03; code_tbl[27] = 8'h01;
        push_exp(1'b1);
        ready_b = 1'b1;
        run_frame(1'b1, 144);

        // Threshold saturation near the top of the 10-bit range.
        mem_b[0]  = 10'd1022; mem_b[1]  = 10'd1022; mem_b[2]  = 10'd1022;
        mem_b[8]  = 10'd1022; mem_b[9]  = 10'd1021; mem_b[10] = 10'd1022;
        mem_b[16] = 10'd1022; mem_b[17] = 10'd1022; mem_b[18] = 10'd1023;
        set_codes(8'h00);
        code_tbl[9]  = 8'h80; code_tbl[10] = 8'h40; code_tbl[17] = 8'h10;
        code_tbl[11] = 8'h29; code_tbl[19] = 8'h09;
        code_tbl[25] = 8'h07; code_tbl[26] = 8'h03; code_tbl[27] = 8'h01;
        do_reset(1'b1);
        push_exp(1'b1);
        ready_b = 1'b1;
        run_frame(1'b1, 144);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
